// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl: bit-serial magnitude comparator controller.
// Walks two WIDTH-bit operands MSB first through an external one-bit
// comparator slice. The slice's {G,Eq,L} outputs are fed back through a
// cascade register, and the final cascade value is the comparison result.
//
// Optional feature: define SERIAL_CMP_EARLY_EXIT_EN to finish as soon as the
// slice reports a strict inequality, without processing the remaining bits.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start, a_word, b_word      request and operands (captured in IDLE)
//   cmp_a, cmp_b               current operand bits to the slice
//   cmp_in_g/eq/l              cascade inputs to the slice
//   cmp_G, cmp_Eq, cmp_L       slice outputs
//   busy                       high while bits are being processed
//   done                       one-cycle pulse when gt/eq/lt become valid
//   gt, eq, lt                 result, held until the next accepted start
//   err                        sticky: slice output was not one-hot
module serial_compare_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  output logic             cmp_a,
  output logic             cmp_b,
  output logic             cmp_in_g,
  output logic             cmp_in_eq,
  output logic             cmp_in_l,
  input  logic             cmp_G,
  input  logic             cmp_Eq,
  input  logic             cmp_L,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             err
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [IDX_W-1:0]   idx;
  logic [2:0]         casc;      // {g, eq, l}
  logic [2:0]         slice_out;
  logic               last_bit;

  assign slice_out = {cmp_G, cmp_Eq, cmp_L};

  // Decide whether this RUN edge is the final one.
`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign last_bit = (idx == '0) || cmp_G || cmp_L;
`else
  assign last_bit = (idx == '0);
`endif

  // Slice drive: only meaningful in RUN, forced quiet elsewhere.
  always_comb begin
    cmp_a     = 1'b0;
    cmp_b     = 1'b0;
    cmp_in_g  = 1'b0;
    cmp_in_eq = 1'b0;
    cmp_in_l  = 1'b0;
    if (state == S_RUN) begin
      cmp_a     = a_reg[idx];
      cmp_b     = b_reg[idx];
      cmp_in_g  = casc[2];
      cmp_in_eq = casc[1];
      cmp_in_l  = casc[0];
    end
  end

  // Control FSM with registered status/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a_reg <= '0;
      b_reg <= '0;
      idx   <= '0;
      casc  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg <= a_word;
            b_reg <= b_word;
            idx   <= IDX_W'(WIDTH - 1);
            casc  <= 3'b010;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          casc <= slice_out;
          idx  <= idx - IDX_W'(1);
          // A malformed slice response is flagged but still propagated raw.
          if (!$onehot(slice_out)) begin
            err <= 1'b1;
          end
          if (last_bit) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            gt    <= cmp_G;
            eq    <= cmp_Eq;
            lt    <= cmp_L;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Scoreboard bench for serial_compare_ctrl (WIDTH=8) with an ideal one-bit
// comparator slice that can be forced to emit an illegal G=L=1 response.
module tb_serial_compare_ctrl;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a_word;
  logic [7:0] b_word;
  logic       cmp_a, cmp_b, cmp_in_g, cmp_in_eq, cmp_in_l;
  logic       cmp_G, cmp_Eq, cmp_L;
  logic       busy, done, gt, eq, lt, err;
  logic       inject;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  typedef struct {
    logic [3:0] res;       // {gt, eq, lt, err}
    int         done_edge; // edge after which done is visible
  } exp_t;

  exp_t sb[$];

  serial_compare_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_word   (a_word),
    .b_word   (b_word),
    .cmp_a    (cmp_a),
    .cmp_b    (cmp_b),
    .cmp_in_g (cmp_in_g),
    .cmp_in_eq(cmp_in_eq),
    .cmp_in_l (cmp_in_l),
    .cmp_G    (cmp_G),
    .cmp_Eq   (cmp_Eq),
    .cmp_L    (cmp_L),
    .busy     (busy),
    .done     (done),
    .gt       (gt),
    .eq       (eq),
    .lt       (lt),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Ideal cascaded one-bit comparator, optionally forced to an illegal code.
  always_comb begin
    if (inject) begin
      {cmp_G, cmp_Eq, cmp_L} = 3'b101;
    end else begin
      cmp_G  = cmp_in_g | (cmp_in_eq & cmp_a & ~cmp_b);
      cmp_L  = cmp_in_l | (cmp_in_eq & ~cmp_a & cmp_b);
      cmp_Eq = cmp_in_eq & (cmp_a == cmp_b);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_gt_eq_lt_err", 32'({gt, eq, lt, err}), 32'(e.res));
        check("done_latency", 32'(cyc), 32'(e.done_edge));
        check("busy_low_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Present a start for one cycle; returns just after the accepting edge k.
  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] res, input int nrun, input bit expect_it,
                       output int k);
    @(posedge clk); #1;
    a_word = a;
    b_word = b;
    start  = 1'b1;
    k      = cyc + 1;
    if (expect_it) sb.push_back('{res, k + nrun});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait (bounded) until every expected result has been observed.
  task automatic drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0 && !busy && !done) break;
      @(posedge clk); #1;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int k2;
    rst    = 1'b1;
    start  = 1'b0;
    a_word = 8'h00;
    b_word = 8'h00;
    inject = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({busy, done, gt, eq, lt, err}), 32'd0);
    check("reset_slice_drive", 32'({cmp_a, cmp_b, cmp_in_g, cmp_in_eq, cmp_in_l}), 32'd0);
    rst = 1'b0;

    // Equal operands: full length, eq result.
    issue(8'h5A, 8'h5A, 4'b0100, 8, 1'b1, k);
    check("eq_busy_first_run", 32'(busy), 32'd1);
    check("eq_first_slice_drive", 32'({cmp_a, cmp_b, cmp_in_g, cmp_in_eq, cmp_in_l}), 32'b00010);
    drain("drain_eq");

    // MSB decides: early exit shortens the run.
    issue(8'h80, 8'h7F, 4'b1000, EARLY ? 1 : 8, 1'b1, k);
    check("gt_first_slice_drive", 32'({cmp_a, cmp_b, cmp_in_g, cmp_in_eq, cmp_in_l}), 32'b10010);
    drain("drain_gt");

    // LSB decides: full length in both builds.
    issue(8'h00, 8'h01, 4'b0010, 8, 1'b1, k);
    drain("drain_lt");

    // A start pulse during RUN with new operands must be ignored.
    issue(8'h3C, 8'h3D, 4'b0010, 8, 1'b1, k);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_word = 8'hFF;
    b_word = 8'h00;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_ignored_start", 32'(busy), 32'd1);
    drain("drain_ignored_start");

    // Start held high: re-accepted on the first IDLE cycle after DONE.
    @(posedge clk); #1;
    a_word = 8'h40;
    b_word = 8'h40;
    start  = 1'b1;
    k      = cyc + 1;
    sb.push_back('{4'b0100, k + 8});
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_word = 8'h41;
    k2     = k + 10;
    sb.push_back('{4'b1000, k2 + 8});
    repeat (9) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("held_start_reaccepted", 32'(busy), 32'd1);
    drain("drain_held_start");

    // Illegal slice response on the third bit: err set, raw values kept.
    issue(8'h33, 8'h33, 4'b1011, EARLY ? 3 : 8, 1'b1, k);
    @(posedge clk); #1;
    @(posedge clk); #1;
    inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    drain("drain_inject");
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky_after_done", 32'({gt, lt, err}), 32'b111);

    // Next accepted start clears err and the previous result.
    issue(8'h00, 8'h01, 4'b0010, 8, 1'b1, k);
    check("err_cleared_on_start", 32'({gt, eq, lt, err}), 32'd0);
    drain("drain_after_err");
    check("lt_held_before_reset", 32'({gt, eq, lt}), 32'b001);

    // Reset mid-RUN abandons the comparison; no done may follow.
    issue(8'h12, 8'h34, 4'b0000, 8, 1'b0, k);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrun_reset_outputs", 32'({busy, done, gt, eq, lt, err}), 32'd0);
    check("midrun_reset_slice_drive", 32'({cmp_a, cmp_b, cmp_in_g, cmp_in_eq, cmp_in_l}), 32'd0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("no_pending_after_reset", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_compare_ctrl.md
SERIAL_COMPARE_CTRL -- requirements
Module: serial_compare_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a comparison; sampled only in IDLE.
REQ-005 SHALL have ports a_word, b_word  input  WIDTH  operands; captured on an accepted start.
REQ-006 SHALL have ports cmp_a, cmp_b  output  1  bit pair driven to the external one-bit comparator slice.
REQ-007 SHALL have ports cmp_in_g, cmp_in_eq, cmp_in_l  output  1  cascade inputs to the slice.
REQ-008 SHALL have ports cmp_G, cmp_Eq, cmp_L  input  1  slice outputs.
REQ-009 SHALL have port busy  output  1  high while in RUN.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the result becomes valid.
REQ-011 SHALL have ports gt, eq, lt  output  1  registered result (a_word > / = / < b_word), held until the next accepted start.
REQ-012 SHALL have port err  output  1  sticky flag: slice output was not one-hot.

Function
REQ-013 SHALL implement the states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE with start=1, capture a_word/b_word, set bit index to WIDTH-1, set cascade register {g,eq,l}=010, clear gt/eq/lt/err, and enter RUN.
REQ-015 SHALL, in RUN, combinationally drive cmp_a=a_reg[idx], cmp_b=b_reg[idx] and cmp_in_g/eq/l from the cascade register, processing bits MSB first.
REQ-016 SHALL, at each RUN edge, load the cascade register from cmp_G/cmp_Eq/cmp_L, decrement idx, and enter DONE after the idx=0 cycle.
REQ-017 SHALL drive all cmp_* outputs to 0 outside RUN.
REQ-018 SHALL, on entry to DONE, copy the cascade register to gt/eq/lt and assert done for exactly one cycle, then return to IDLE.
REQ-019 SHALL ignore start in RUN and DONE; a start held high SHALL be accepted on the first IDLE cycle after DONE.
REQ-020 SHALL give latency: start sampled at edge k -> busy in cycles k+1..k+WIDTH, done and valid result in cycle k+WIDTH+1 (full-length case).
REQ-021 SHALL set err at any RUN edge where {cmp_G,cmp_Eq,cmp_L} is not one-hot; the comparison SHALL still complete using the raw values.

Reset
REQ-022 SHALL, on rst=1 at a clock edge, enter IDLE and clear busy, done, gt, eq, lt, err, idx and the cascade register, regardless of state.
REQ-023 SHALL abandon a comparison when reset occurs mid-RUN; done SHALL NOT pulse for that comparison.

Configuration
REQ-024 SHALL support the macro SERIAL_CMP_EARLY_EXIT_EN.
REQ-025 SHALL, when the macro is defined, enter DONE on the RUN edge where cmp_G or cmp_L is 1, skipping the remaining bits.
REQ-026 SHALL, when the macro is undefined, always spend exactly WIDTH cycles in RUN.

Verification (WIDTH=8, ideal slice model)
REQ-027 SHALL test a=0x5A, b=0x5A -> eq=1, gt=lt=0, done in cycle k+9, err=0.
REQ-028 SHALL test a=0x80, b=0x7F -> gt=1; done in cycle k+2 with SERIAL_CMP_EARLY_EXIT_EN, cycle k+9 without.
REQ-029 SHALL test a=0x00, b=0x01 -> lt=1, done in cycle k+9 in both builds.
REQ-030 SHALL test a pulse on start in cycle k+3 with new operands -> ignored; the result matches the original operands.
REQ-031 SHALL test rst asserted in cycle k+4 -> IDLE next cycle, done never pulses, gt=eq=lt=0.
REQ-032 SHALL test a slice model forcing cmp_G=cmp_L=1 for one bit -> err=1 until the next accepted start or reset.
